vga_rx_monitor: RTL and testbench
=================================

Name: vga_rx_monitor

Overview:
- Receiving end of the VGA interface driven by ModuloVGA.
- Samples HS/VS/video_on/COLOR_OUT on the pixel-tick enable and recovers line/frame timing and pixel coordinates.
- Produces a per-frame 16-bit colour checksum and lock/error status.
- Used in benches and on-chip as a self-check of the VGA controller, replacing text-dump inspection of the screen.

Parameters:
- H_TOTAL, 800, pixel ticks per line
- V_TOTAL, 525, lines per frame
- H_ACTIVE, 640, video_on ticks per line
- V_ACTIVE, 480, lines containing video_on per frame
- SYNC_LOW, 1, 1 = HS/VS asserted low

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- pix_en  in  1  pixel tick (ENClock); all sampling happens only on cycles with pix_en=1
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync
- de_in  in  1  video_on
- color_in  in  12  COLOR_OUT
- pix_valid  out  1  captured-pixel strobe
- pix_x  out  10  column of captured pixel
- pix_y  out  10  row of captured pixel
- pix_data  out  12  captured colour
- line_len  out  10  last measured HS period, in ticks
- frame_lines  out  10  last measured VS period, in lines
- frame_sum  out  16  checksum of last complete frame
- frame_done  out  1  one-cycle pulse when frame_sum/frame_lines update
- locked  out  1  state==LOCKED
- timing_err  out  1  sticky error flag

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; counters 0; state SEARCH; edge-detect history set to deasserted sync.
- Edges: a sync "edge" is a tick where the sync is asserted (per SYNC_LOW) and was deasserted on the previous tick. Edge detection uses the previous pix_en tick, not the previous clk.
- pix_en=0 cycles: every register holds, except pix_valid and frame_done, which go to 0.
- hcnt:
  - Cleared to 0 on an HS edge tick; otherwise +1 per tick, saturating at 1023.
  - On an HS edge: line_len <= hcnt+1, saturating at 1023. A 800-tick period gives 800.
- vcnt:
  - +1 on each HS edge, saturating at 1023; cleared to 0 on a VS edge.
  - On a VS edge: frame_lines <= vcnt+1; frame_done=1 on the next cycle.
- HS and VS edge on the same tick: both processed. vcnt is cleared (VS priority over increment); line_len updates and hcnt clears.
- Pixel capture:
  - On a tick with de_in=1, the next cycle has pix_valid=1, pix_data=color_in, pix_x=xcnt, pix_y=ycnt (1-cycle latency).
  - xcnt: +1 per de tick, cleared on HS edge.
  - ycnt: +1 on the first HS edge following a line that had ≥1 de tick, cleared on VS edge.
- Checksum: acc <= acc + {4'b0,color_in} mod 2^16 per de tick. On a VS edge, frame_sum <= acc (including the current tick's contribution if de is also 1) and acc <= 0.
- Per-line check, at each HS edge: line_ok = (line_len_new==H_TOTAL) && (xcnt==H_ACTIVE or xcnt==0). A line with xcnt==0 is blanking.
- Per-frame check, at VS edge: frame_ok = (frame_lines_new==V_TOTAL) && (ycnt==V_ACTIVE) && all line_ok since the previous VS edge.
- FSM:
  - SEARCH: on first VS edge -> MEASURE; no checks, and the partial frame is discarded (frame_done still pulses).
  - MEASURE: at VS edge, frame_ok -> LOCKED; else stay in MEASURE.
  - LOCKED: a failing line_ok at an HS edge, or a failing frame_ok at a VS edge -> SEARCH, and timing_err <= 1 on the same cycle.
- timing_err is cleared only by reset.
- Reset mid-frame: the full reset applies immediately, and lock requires a fresh VS edge followed by one good frame.

Test Plan:
- Nominal 640x480@60, pix_en every 4th clk, 3 frames -> line_len=800 and frame_lines=525 after first VS edge; locked=1 on the cycle after the second VS edge; timing_err=0.
- Constant color_in=12'hABC for all active pixels, one full locked frame -> frame_sum=16'h4000; frame_done pulses exactly once per VS edge.
- Coordinate sweep -> first pix_valid of a frame has pix_x=0, pix_y=0; last has pix_x=639, pix_y=479; exactly 307200 pix_valid pulses per frame.
- While locked, shorten one line to 799 ticks -> at that HS edge line_len=799, locked=0 and timing_err=1. Relock occurs at the end of the first full good frame after the next VS edge, with timing_err still 1.
- pix_en held low 10 clk mid-line -> no output or counter change and no pix_valid; capture resumes correctly.
- rst=0 for one clk mid-frame -> all outputs 0 and state SEARCH. Relock requires a VS edge plus one good frame; HS and VS asserted on the same tick gives vcnt=0 and an updated line_len.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// VGA receive-side monitor: recovers line/frame timing and pixel coordinates from sampled
// sync/video_on, and reports a per-frame colour checksum with lock and sticky error status.
module vga_rx_monitor #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned SYNC_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic [11:0] color_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_data,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic [15:0] frame_sum,
    output logic        frame_done,
    output logic        locked,
    output logic        timing_err
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned CLR_W = 12;
    localparam int unsigned SUM_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic               hs_prev_q, hs_prev_d;
    logic               vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   vcnt_q, vcnt_d;
    logic [CNT_W-1:0]   xcnt_q, xcnt_d;
    logic [CNT_W-1:0]   ycnt_q, ycnt_d;
    logic               line_de_q, line_de_d;
    logic               lines_ok_q, lines_ok_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic               pix_valid_q, pix_valid_d;
    logic [CNT_W-1:0]   pix_x_q, pix_x_d;
    logic [CNT_W-1:0]   pix_y_q, pix_y_d;
    logic [CLR_W-1:0]   pix_data_q, pix_data_d;
    logic [CNT_W-1:0]   line_len_q, line_len_d;
    logic [CNT_W-1:0]   frame_lines_q, frame_lines_d;
    logic [SUM_W-1:0]   frame_sum_q, frame_sum_d;
    logic               frame_done_q, frame_done_d;
    logic               locked_q, locked_d;
    logic               timing_err_q, timing_err_d;

    logic               hs_act, vs_act, hs_edge, vs_edge;
    logic [CNT_W-1:0]   line_len_new, frame_lines_new;
    logic [SUM_W-1:0]   acc_sum;
    logic               line_ok, frame_ok;

    // Edge detection is against the previous pix_en tick, not the previous clk.
    assign hs_act  = (SYNC_LOW != 0) ? ~hs_in : hs_in;
    assign vs_act  = (SYNC_LOW != 0) ? ~vs_in : vs_in;
    assign hs_edge = pix_en & hs_act & ~hs_prev_q;
    assign vs_edge = pix_en & vs_act & ~vs_prev_q;

    assign line_len_new    = sat_inc(hcnt_q);
    assign frame_lines_new = sat_inc(vcnt_q);
    assign acc_sum         = acc_q + (de_in ? SUM_W'(color_in) : SUM_W'(0));

    // A good line has the nominal period and is either fully active or pure blanking.
    assign line_ok  = (line_len_new == CNT_W'(H_TOTAL)) &&
                      ((xcnt_q == CNT_W'(H_ACTIVE)) || (xcnt_q == '0));
    assign frame_ok = (frame_lines_new == CNT_W'(V_TOTAL)) &&
                      (ycnt_q == CNT_W'(V_ACTIVE)) && lines_ok_q &&
                      (!hs_edge || line_ok);

    always_comb begin
        state_d       = state_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        xcnt_d        = xcnt_q;
        ycnt_d        = ycnt_q;
        line_de_d     = line_de_q;
        lines_ok_d    = lines_ok_q;
        acc_d         = acc_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_data_d    = pix_data_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        frame_sum_d   = frame_sum_q;
        frame_done_d  = 1'b0;
        timing_err_d  = timing_err_q;

        if (pix_en) begin
            hs_prev_d   = hs_act;
            vs_prev_d   = vs_act;
            pix_valid_d = de_in;
            if (de_in) begin
                pix_x_d    = xcnt_q;
                pix_y_d    = ycnt_q;
                pix_data_d = color_in;
            end

            hcnt_d    = hs_edge ? '0 : sat_inc(hcnt_q);
            xcnt_d    = hs_edge ? '0 : (de_in ? sat_inc(xcnt_q) : xcnt_q);
            line_de_d = hs_edge ? 1'b0 : (line_de_q | de_in);
            acc_d     = vs_edge ? '0 : acc_sum;

            if (hs_edge) begin
                line_len_d = line_len_new;
                lines_ok_d = lines_ok_q & line_ok;
                vcnt_d     = sat_inc(vcnt_q);
                if (line_de_q) begin
                    ycnt_d = sat_inc(ycnt_q);
                end
            end

            // VS edge takes priority over the line-count increment of a coincident HS edge.
            if (vs_edge) begin
                vcnt_d        = '0;
                ycnt_d        = '0;
                lines_ok_d    = 1'b1;
                frame_lines_d = frame_lines_new;
                frame_sum_d   = acc_sum;
                frame_done_d  = 1'b1;
            end

            case (state_q)
                SEARCH: begin
                    if (vs_edge) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (vs_edge && frame_ok) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if ((hs_edge && !line_ok) || (vs_edge && !frame_ok)) begin
                        state_d      = SEARCH;
                        timing_err_d = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= SEARCH;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            xcnt_q        <= '0;
            ycnt_q        <= '0;
            line_de_q     <= 1'b0;
            lines_ok_q    <= 1'b1;
            acc_q         <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            frame_sum_q   <= '0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            xcnt_q        <= xcnt_d;
            ycnt_q        <= ycnt_d;
            line_de_q     <= line_de_d;
            lines_ok_q    <= lines_ok_d;
            acc_q         <= acc_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            frame_sum_q   <= frame_sum_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_sum   = frame_sum_q;
    assign frame_done  = frame_done_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a reduced 40x20 raster: a timing generator drives the DUT,
// an event-based reference model predicts every output each clock.
module tb_vga_rx_monitor;

    localparam int HT = 40;
    localparam int VT = 20;
    localparam int HA = 24;
    localparam int VA = 12;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        hs_in;
    logic        vs_in;
    logic        de_in;
    logic [11:0] color_in;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_data;
    logic [9:0]  line_len;
    logic [9:0]  frame_lines;
    logic [15:0] frame_sum;
    logic        frame_done;
    logic        locked;
    logic        timing_err;

    vga_rx_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hs_in(hs_in), .vs_in(vs_in),
        .de_in(de_in), .color_in(color_in), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_data(pix_data), .line_len(line_len),
        .frame_lines(frame_lines), .frame_sum(frame_sum), .frame_done(frame_done),
        .locked(locked), .timing_err(timing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: timestamps and event counts since the last sync edges.
    int m_t, m_last_hs, m_hs_since_vs, m_xin, m_rows, m_sum;
    int m_ll, m_fl, m_fs, m_px, m_py, m_pd;
    bit m_hs_prev, m_vs_prev, m_had, m_all_ok, m_locked, m_seen, m_err, m_pv, m_fd;

    // Raster generator and stimulus control.
    int gh = 0, gv = 0, phase = 0, short_v = -1;
    bit short_armed = 0, const_mode = 0, rand_mode = 0;
    int pv_cnt, fd_cnt, first_x, first_y, last_x, last_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_last_hs = -1; m_hs_since_vs = 0; m_xin = 0; m_rows = 0; m_sum = 0;
        m_ll = 0; m_fl = 0; m_fs = 0; m_px = 0; m_py = 0; m_pd = 0;
        m_hs_prev = 0; m_vs_prev = 0; m_had = 0; m_all_ok = 1;
        m_locked = 0; m_seen = 0; m_err = 0; m_pv = 0; m_fd = 0;
    endtask

    task automatic model_tick(input bit pe, input bit hs, input bit vs, input bit de,
                              input logic [11:0] col);
        bit hs_a, vs_a, hs_e, vs_e, lok, fok;
        int ll, fl, x_now, y_now;
        m_pv = 0;
        m_fd = 0;
        if (!pe) return;
        hs_a = !hs;
        vs_a = !vs;
        hs_e = hs_a && !m_hs_prev;
        vs_e = vs_a && !m_vs_prev;
        m_hs_prev = hs_a;
        m_vs_prev = vs_a;
        x_now = m_xin;
        y_now = m_rows;
        if (de) begin
            m_pv = 1; m_px = x_now; m_py = y_now; m_pd = int'(col);
        end
        ll  = (m_t - m_last_hs > 1023) ? 1023 : m_t - m_last_hs;
        fl  = (m_hs_since_vs + 1 > 1023) ? 1023 : m_hs_since_vs + 1;
        lok = (ll == HT) && (x_now == HA || x_now == 0);
        fok = (fl == VT) && (y_now == VA) && m_all_ok && (!hs_e || lok);
        m_sum = (m_sum + (de ? int'(col) : 0)) % 65536;
        if (hs_e) begin
            m_ll = ll;
            m_last_hs = m_t;
            m_all_ok = m_all_ok && lok;
            if (m_had) m_rows++;
            m_hs_since_vs++;
            m_xin = 0;
            m_had = 0;
        end else if (de) begin
            m_xin++;
            m_had = 1;
        end
        if (vs_e) begin
            m_fl = fl; m_fs = m_sum; m_sum = 0;
            m_hs_since_vs = 0; m_rows = 0; m_all_ok = 1; m_fd = 1;
        end
        if (m_locked) begin
            if ((hs_e && !lok) || (vs_e && !fok)) begin
                m_locked = 0; m_seen = 0; m_err = 1;
            end
        end else if (vs_e) begin
            if (m_seen && fok) m_locked = 1;
            m_seen = 1;
        end
        m_t++;
    endtask

    task automatic check_all();
        chk("pix_valid",   32'(pix_valid),   32'(m_pv));
        chk("pix_x",       32'(pix_x),       32'(m_px));
        chk("pix_y",       32'(pix_y),       32'(m_py));
        chk("pix_data",    32'(pix_data),    32'(m_pd));
        chk("line_len",    32'(line_len),    32'(m_ll));
        chk("frame_lines", 32'(frame_lines), 32'(m_fl));
        chk("frame_sum",   32'(frame_sum),   32'(m_fs));
        chk("frame_done",  32'(frame_done),  32'(m_fd));
        chk("locked",      32'(locked),      32'(m_locked));
        chk("timing_err",  32'(timing_err),  32'(m_err));
    endtask

    // One clock: a raster tick when pe=1, otherwise random garbage the DUT must ignore.
    task automatic clk_step(input bit pe);
        bit h, v, d;
        logic [11:0] c;
        int len;
        if (pe) begin
            h = !(gh < 4);
            v = !(gv < 2);
            d = (gh >= 8) && (gh < 8 + HA) && (gv >= 3) && (gv < 3 + VA);
            c = const_mode ? 12'hABC : 12'($urandom);
            len = (short_armed && gv == short_v) ? HT - 1 : HT;
            gh++;
            if (gh >= len) begin
                if (short_armed && gv == short_v) short_armed = 0;
                gh = 0;
                gv = (gv + 1) % VT;
            end
        end else begin
            h = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            c = 12'($urandom);
        end
        pix_en = pe; hs_in = h; vs_in = v; de_in = d; color_in = c;
        @(posedge clk);
        if (rst) model_tick(pe, h, v, d, c);
        else model_reset();
        #1;
        check_all();
        if (pix_valid) begin
            if (pv_cnt == 0) begin first_x = int'(pix_x); first_y = int'(pix_y); end
            last_x = int'(pix_x);
            last_y = int'(pix_y);
            pv_cnt++;
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic one_tick();
        bit pe;
        for (int i = 0; ; i++) begin
            if (rand_mode) pe = ($urandom_range(0, 2) == 0) || (i >= 8);
            else begin pe = (phase == 3); phase = (phase + 1) % 4; end
            clk_step(pe);
            if (pe) break;
        end
    endtask

    // Issue raster ticks up to and including the first tick of line v.
    task automatic run_to(input int v);
        int n = 0;
        while (!(gv == v && gh == 0) && n < 2 * VT * HT) begin
            one_tick();
            n++;
        end
        chk("run_to_bound", 32'(n < 2 * VT * HT), 32'd1);
        one_tick();
    endtask

    task automatic reset_pulse(input bit pe);
        rst = 1'b0;
        clk_step(pe);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0;
        color_in = '0;
        model_reset();
        pv_cnt = 0; fd_cnt = 0; first_x = 0; first_y = 0; last_x = 0; last_y = 0;

        reset_pulse(1'b0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_frame_sum", 32'(frame_sum), 32'd0);

        // Nominal timing, pix_en every 4th clk: first VS -> MEASURE, second VS -> LOCKED.
        run_to(0);
        chk("vs1_locked", 32'(locked), 32'd0);
        chk("vs1_frame_done", 32'(frame_done), 32'd1);
        run_to(0);
        chk("vs2_locked", 32'(locked), 32'd1);
        chk("vs2_line_len", 32'(line_len), 32'(HT));
        chk("vs2_frame_lines", 32'(frame_lines), 32'(VT));
        chk("vs2_timing_err", 32'(timing_err), 32'd0);

        // Constant colour frame: 288 pixels of 12'hABC sum to 16'h1380.
        const_mode = 1; pv_cnt = 0; fd_cnt = 0;
        run_to(0);
        const_mode = 0;
        chk("const_sum", 32'(frame_sum), 32'h1380);
        chk("const_pv_cnt", 32'(pv_cnt), 32'(HA * VA));
        chk("const_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("const_first_x", 32'(first_x), 32'd0);
        chk("const_first_y", 32'(first_y), 32'd0);
        chk("const_last_x", 32'(last_x), 32'(HA - 1));
        chk("const_last_y", 32'(last_y), 32'(VA - 1));

        // Random pix_en and colours, with a 10-clk pix_en gap in the middle of active video.
        rand_mode = 1; pv_cnt = 0;
        run_to(8);
        for (int i = 0; i < 12; i++) one_tick();
        for (int i = 0; i < 10; i++) begin
            clk_step(1'b0);
            chk("hold_pix_valid", 32'(pix_valid), 32'd0);
        end
        run_to(0);
        chk("rand_locked", 32'(locked), 32'd1);
        chk("rand_pv_cnt", 32'(pv_cnt), 32'(HA * VA));
        chk("rand_last_x", 32'(last_x), 32'(HA - 1));
        chk("rand_last_y", 32'(last_y), 32'(VA - 1));

        // One short line while locked: lock drops at its HS edge, relock after a good frame.
        rand_mode = 0; short_v = 5; short_armed = 1;
        run_to(6);
        chk("short_line_len", 32'(line_len), 32'(HT - 1));
        chk("short_locked", 32'(locked), 32'd0);
        chk("short_timing_err", 32'(timing_err), 32'd1);
        run_to(0);
        chk("short_vs_a_locked", 32'(locked), 32'd0);
        run_to(0);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_timing_err", 32'(timing_err), 32'd1);

        // Reset mid-frame, then a coincident HS+VS edge clears the line count.
        rand_mode = 1;
        run_to(7);
        for (int i = 0; i < 5; i++) one_tick();
        reset_pulse(1'b1);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_timing_err", 32'(timing_err), 32'd0);
        chk("mid_rst_line_len", 32'(line_len), 32'd0);
        run_to(0);
        chk("post_rst_line_len", 32'(line_len), 32'(HT));
        chk("post_rst_frame_lines", 32'(frame_lines), 32'd13);
        chk("post_rst_locked", 32'(locked), 32'd0);
        run_to(0);
        chk("post_rst_full_lines", 32'(frame_lines), 32'(VT));
        chk("post_rst_relock", 32'(locked), 32'd1);
        chk("post_rst_timing_err", 32'(timing_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
